// File: rtl/gift_pipe_pkg.sv
// Shared constants for the GIFT-128 pipeline output path.
package gift_pipe_pkg;

    localparam int unsigned GIFT_BLOCK_W = 128;
    localparam int unsigned GIFT_WORD_W  = 32;

    function automatic int unsigned wordsPerBlock(input int unsigned dataW,
                                                  input int unsigned wordW);
        return dataW / wordW;
    endfunction

endpackage

// File: rtl/gift_pipe_block_fifo.sv
// DEPTH x DATA_W register FIFO; exposes head and the entry behind it so the
// serializer can preload its output registers.
module gift_pipe_block_fifo #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   inClk,
    input  logic                   inRstN,
    input  logic                   inPush,
    input  logic                   inPop,
    input  logic [DATA_W-1:0]      inData,
    output logic [DATA_W-1:0]      outHead,
    output logic [DATA_W-1:0]      outSecond,
    output logic                   outFull,
    output logic                   outEmpty,
    output logic [$clog2(DEPTH):0] outLevel
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     rdPtrNext;
    logic [LW-1:0]     count;
    logic              doPush;
    logic              doPop;

    assign outFull   = (count == LW'(DEPTH));
    assign outEmpty  = (count == '0);
    assign doPop     = inPop && !outEmpty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign doPush    = inPush && (!outFull || doPop);
    assign rdPtrNext = rdPtr + 1'b1;
    assign outHead   = mem[rdPtr];
    assign outSecond = mem[rdPtrNext];
    assign outLevel  = count;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= inData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtrNext;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gift_pipe_data_out_serializer.sv
// Buffers finished GIFT blocks and streams them MSW-first as WORD_W-bit words
// over valid/ready; drops on overflow are reported through a sticky flag.
module gift_pipe_data_out_serializer
    import gift_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = GIFT_BLOCK_W,
    parameter int unsigned WORD_W = GIFT_WORD_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   inClk,
    input  logic                   inRstN,
    input  logic                   inValid,
    input  logic [DATA_W-1:0]      inData,
    input  logic                   inReady,
    output logic                   outValid,
    output logic [WORD_W-1:0]      outWord,
    output logic                   outLast,
    output logic                   outFull,
    output logic [$clog2(DEPTH):0] outLevel,
    output logic                   outOverflow,
    input  logic                   inClrOvf
);

    localparam int unsigned N  = wordsPerBlock(DATA_W, WORD_W);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] fifoHead;
    logic [DATA_W-1:0] fifoSecond;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [LW-1:0]     fifoLevel;

    logic [IW-1:0]     wordIdx;
    logic [IW-1:0]     wordIdxD;
    logic              xfer;
    logic              pop;
    logic              pushOk;
    logic              drop;
    logic              hasNext;
    logic [DATA_W-1:0] nextHead;
    logic [DATA_W-1:0] shifted;
    logic              validD;
    logic [WORD_W-1:0] wordD;
    logic              lastD;
    logic              ovfD;

    assign xfer   = outValid && inReady;
    assign pop    = xfer && outLast;
    assign pushOk = inValid && (!fifoFull || pop);
    assign drop   = inValid && fifoFull && !pop;

    gift_pipe_block_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .inClk     (inClk),
        .inRstN    (inRstN),
        .inPush    (pushOk),
        .inPop     (pop),
        .inData    (inData),
        .outHead   (fifoHead),
        .outSecond (fifoSecond),
        .outFull   (fifoFull),
        .outEmpty  (fifoEmpty),
        .outLevel  (fifoLevel)
    );

    // Output registers are loaded from the block that will be at the head
    // after this edge, so a push into an empty buffer shows word 0 next cycle.
    always_comb begin
        wordIdxD = wordIdx;
        hasNext  = 1'b0;
        nextHead = fifoHead;
        if (xfer) begin
            wordIdxD = outLast ? '0 : wordIdx + 1'b1;
        end
        if (pop) begin
            hasNext  = (fifoLevel >= LW'(2)) || pushOk;
            nextHead = (fifoLevel >= LW'(2)) ? fifoSecond : inData;
        end else begin
            hasNext  = !fifoEmpty || pushOk;
            nextHead = fifoEmpty ? inData : fifoHead;
        end
        shifted = nextHead << (int'(wordIdxD) * WORD_W);
        validD  = hasNext;
        wordD   = hasNext ? shifted[DATA_W-1 -: WORD_W] : '0;
        lastD   = hasNext && (wordIdxD == IW'(N - 1));
        // A drop in the same cycle as a clear keeps the flag set.
        ovfD    = drop ? 1'b1 : (inClrOvf ? 1'b0 : outOverflow);
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            wordIdx     <= '0;
            outValid    <= 1'b0;
            outWord     <= '0;
            outLast     <= 1'b0;
            outOverflow <= 1'b0;
        end else begin
            wordIdx     <= wordIdxD;
            outValid    <= validD;
            outWord     <= wordD;
            outLast     <= lastD;
            outOverflow <= ovfD;
        end
    end

    assign outFull  = fifoFull;
    assign outLevel = fifoLevel;

endmodule

// File: tb/tb_gift_pipe_data_out_serializer.sv
// Directed and randomized checks of the block serializer against a queue model.
module tb_gift_pipe_data_out_serializer;

    localparam int DEPTH = 4;
    localparam int NW    = 4;

    logic         clk = 1'b0;
    logic         rstN;
    logic         inValid;
    logic [127:0] inData;
    logic         inReady;
    logic         inClrOvf;
    logic         outValid;
    logic [31:0]  outWord;
    logic         outLast;
    logic         outFull;
    logic [2:0]   outLevel;
    logic         outOverflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of buffered blocks, words already sent from the head.
    logic [127:0] q[$];
    int           sent = 0;
    logic         ovf  = 1'b0;

    always #5 clk = ~clk;

    gift_pipe_data_out_serializer #(
        .DATA_W (128),
        .WORD_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .inClk       (clk),
        .inRstN      (rstN),
        .inValid     (inValid),
        .inData      (inData),
        .inReady     (inReady),
        .outValid    (outValid),
        .outWord     (outWord),
        .outLast     (outLast),
        .outFull     (outFull),
        .outLevel    (outLevel),
        .outOverflow (outOverflow),
        .inClrOvf    (inClrOvf)
    );

    function automatic logic [31:0] wordOf(input logic [127:0] b, input int k);
        logic [127:0] s;
        s = b >> ((NW - 1 - k) * 32);
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        logic        ev;
        logic [31:0] ew;
        ev = (q.size() > 0);
        ew = ev ? wordOf(q[0], sent) : 32'h0;
        check("valid", outValid, ev);
        check("word", outWord, ew);
        check("last", outLast, ev && (sent == NW - 1));
        check("level", outLevel, q.size());
        check("full", outFull, q.size() == DEPTH);
        check("overflow", outOverflow, ovf);
    endtask

    task automatic modelReset();
        q.delete();
        sent = 0;
        ovf  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic v, input logic [127:0] d, input logic r, input logic clr);
        logic xf;
        logic lastXf;
        logic wasFull;
        inValid  = v;
        inData   = d;
        inReady  = r;
        inClrOvf = clr;
        xf      = (q.size() > 0) && r;
        lastXf  = xf && (sent == NW - 1);
        wasFull = (q.size() == DEPTH);
        @(posedge clk);
        if (xf) begin
            if (lastXf) begin
                void'(q.pop_front());
                sent = 0;
            end else begin
                sent++;
            end
        end
        if (v && (!wasFull || lastXf)) q.push_back(d);
        if (v && wasFull && !lastXf) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        #1;
        checkAll();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inReady  = 1'b0;
        inClrOvf = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;

        // Single known block at full rate
        cycle(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b0);
        check("firstWord", outWord, 32'h00112233);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure with ready pattern 1,0,0,1,...
        cycle(1'b1, rnd128(), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, '0, (i % 3) == 0, 1'b0);

        // Fill, overflow, clear-vs-drop, clear alone
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0);
        cycle(1'b1, rnd128(), 1'b0, 1'b0);
        cycle(1'b1, rnd128(), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Full + push coinciding with last-word transfer, then drain
        repeat (NW - 1) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 128'hFEEDFACE_0BADF00D_DEADBEEF_CAFEBABE, 1'b1, 1'b0);
        repeat (NW * DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 1) == 1, rnd128(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0);
        end
        repeat (NW * DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-block after two words transferred
        cycle(1'b1, rnd128(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
        cycle(1'b1, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1, 1'b0);
        check("afterRstWord0", outWord, 32'h01234567);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
